// File: rtl/cla_pkg.sv
// Shared types and geometry for the cache-line / memory-burst adaptor.
package cla_pkg;

   localparam int S_LINE      = 256;
   localparam int S_BURST     = 64;
   localparam int BEATS       = S_LINE / S_BURST;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } cla_state_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the line/burst adaptor in one bundle.
interface cacheline_adaptor_if;
   import cla_pkg::*;

   logic [S_LINE-1:0]  line_i;
   logic [S_LINE-1:0]  line_o;
   logic [31:0]        address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   logic [S_BURST-1:0] burst_i;
   logic [S_BURST-1:0] burst_o;
   logic [31:0]        address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );

endinterface

// File: rtl/cacheline_adaptor.sv
// Collects four 64-bit memory beats into a 256-bit fill line and splits a writeback line into four beats.
// Build option CLA_EARLY_RESP_EN: drop DONE and signal completion combinationally on the last beat.
module cacheline_adaptor
   import cla_pkg::*;
(
   input logic          clk,
   input logic          rst,
   cacheline_adaptor_if.slave bus
);

   localparam int SH = $clog2(S_BURST);

   cla_state_t         state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic [S_LINE-1:0]  wline_q, wline_d;
   logic [S_LINE-1:0]  line_q, line_d;
   logic [S_BURST-1:0] burst_q, burst_d;
   logic               rd_q, rd_d;
   logic               wr_q, wr_d;
   logic               beat;
   logic               last_beat;
`ifndef CLA_EARLY_RESP_EN
   logic               resp_q, resp_d;
`endif

   assign beat      = bus.resp_i && (state_q == RD || state_q == WR);
   assign last_beat = beat && (cnt_q == 2'(BEATS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a pending writeback wins over a fill
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.write_i)     state_d = WR;
            else if (bus.read_i) state_d = RD;
         end
         RD, WR: begin
`ifdef CLA_EARLY_RESP_EN
            if (last_beat) state_d = IDLE;
`else
            if (last_beat) state_d = DONE;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latching, beat counting and fill capture
   always_comb begin
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      line_d  = line_q;
      if (state_q == IDLE) begin
         if (bus.write_i) begin
            wline_d = bus.line_i;
            addr_d  = line_align(bus.address_i);
         end else if (bus.read_i) begin
            addr_d  = line_align(bus.address_i);
         end
      end
      if (beat) begin
         // 2-bit counter wraps to zero exactly on the closing beat
         cnt_d = cnt_q + 2'd1;
         if (state_q == RD) begin
            line_d[{cnt_q, {SH{1'b0}}} +: S_BURST] = bus.burst_i;
         end
      end
   end

   // Output logic: registered outputs are decoded from the upcoming state
   always_comb begin
      rd_d    = (state_d == RD);
      wr_d    = (state_d == WR);
      burst_d = wr_d ? wline_d[{cnt_d, {SH{1'b0}}} +: S_BURST] : '0;
`ifndef CLA_EARLY_RESP_EN
      resp_d  = (state_d == DONE);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         burst_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
`ifndef CLA_EARLY_RESP_EN
         resp_q  <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
         burst_q <= burst_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
`ifndef CLA_EARLY_RESP_EN
         resp_q  <= resp_d;
`endif
      end
   end

   // The writeback line is pure payload; it is always reloaded before use
   always_ff @(posedge clk) begin
      wline_q <= wline_d;
   end

   assign bus.read_o    = rd_q;
   assign bus.write_o   = wr_q;
   assign bus.address_o = addr_q;
   assign bus.burst_o   = burst_q;
`ifdef CLA_EARLY_RESP_EN
   assign bus.resp_o = last_beat;
   assign bus.line_o = (last_beat && state_q == RD)
                     ? {bus.burst_i, line_q[S_LINE-S_BURST-1:0]} : line_q;
`else
   assign bus.resp_o = resp_q;
   assign bus.line_o = line_q;
`endif

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Converts between the cache's full-line interface and the 64-bit burst interface of physical memory. On a fill it collects four memory beats into one 256-bit line. On a writeback it splits a 256-bit line into four beats. It sits between the cache datapath (line-wide data array side) and the memory arbiter/DRAM model, and issues exactly one memory transaction per cache request.

## Interface
- s_line, 256, cache line width in bits
- s_burst, 64, memory beat width in bits; beats per line = s_line/s_burst = 4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- line_i  in  s_line  writeback line from cache
- line_o  out  s_line  assembled fill line to cache
- address_i  in  32  cache request byte address
- read_i  in  1  cache fill request
- write_i  in  1  cache writeback request
- resp_o  out  1  one-cycle completion pulse to cache
- burst_i  in  s_burst  memory read beat
- burst_o  out  s_burst  memory write beat
- address_o  out  32  line-aligned memory address
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat strobe, one per beat

## Operation
- Reset values: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0, beat count=0, state IDLE.
- States: IDLE, RD (read burst), WR (write burst), DONE.
- IDLE: on write_i, latch line_i and the aligned address {address_i[31:5],5'b0}, then go to WR. Otherwise, on read_i, latch the address and go to RD.
  - write_i has priority when read_i and write_i are asserted together, because a dirty writeback precedes the refill.
  - resp_i is ignored in IDLE.
- RD: read_o=1.
  - In each cycle with resp_i=1, capture burst_i into line_o[64k +: 64], where k is the beat count, then increment k.
  - When k==3 and resp_i=1, clear k and go to DONE.
- WR: write_o=1, burst_o=latched_line[64k +: 64].
  - In each cycle with resp_i=1, advance k.
  - On the 4th beat, clear k and go to DONE.
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then go to IDLE.
- line_o holds the last completed fill until the next fill's beats overwrite it. It is valid while resp_o=1 after a read.
- Requests are level signals held by the cache until resp_o. Once a transaction is accepted, changes on read_i, write_i, address_i and line_i are ignored until the state returns to IDLE.
- Beat count is 2 bits and wraps 3→0 only at end of burst. Cycles with resp_i=0 stall without advancing.
- Reset mid-burst: all outputs return to reset values at the next edge, the partial line is discarded, and no resp_o is produced.

## Timing
- Request sampled in IDLE at edge t; read_o/write_o/address_o valid from t+1.
- Minimum fill/writeback latency with resp_i held high: request edge → 4 beat cycles → resp_o in the following cycle.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE. There is one idle cycle between transactions at minimum.
- All outputs are registered, except under CLA_EARLY_RESP_EN (see Configuration).

## Configuration
- CLA_EARLY_RESP_EN undefined:
  - DONE state present, behaviour as above.
  - resp_o and line_o are registered.
- CLA_EARLY_RESP_EN defined:
  - DONE is removed.
  - resp_o = resp_i && k==3 in RD/WR, driven combinationally.
  - During a read's final beat, line_o combinationally presents {burst_i, captured[191:0]}, then holds the registered value afterwards.
  - The state returns to IDLE on the edge ending the last beat, which saves one cycle per transaction.

## Structure
- Shared package cla_pkg contains:
  - cla_state_t enum (IDLE, RD, WR, DONE)
  - localparam BEATS = 4
  - localparam OFFSET_BITS = 5
- Single flat module; no sub-module is warranted. The beat counter and line shift/capture register are inline.

## Test plan
- Fill: read_i with address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i high for four cycles.
  - Required: address_o=0x0000_1220.
  - Required: line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
  - Required: resp_o is one single-cycle pulse.
- Writeback: write_i with line_i = {D3,D2,D1,D0}.
  - Required: burst_o shows D0, D1, D2, D3 on successive resp_i cycles, write_o=1 throughout, and read_o never asserts.
- Stalls: resp_i toggles 1,0,0,1,1,0,1 during a fill.
  - Required: exactly 4 beats are captured, in order, and resp_o asserts only after the 4th.
- Simultaneous read_i=write_i=1 in IDLE.
  - Required: the write burst runs first, read_o=0 until it completes, and the read is accepted after resp_o.
- rst asserted after beat 2 of a fill.
  - Required: the next cycle has read_o=0 and line_o=0.
  - Required: a subsequent fill completes correctly with no stale beats and no spurious resp_o.
- With CLA_EARLY_RESP_EN defined, run a fill with resp_i held high.
  - Required: resp_o is asserted in the 4th beat cycle, line_o is correct in that same cycle, and the next request is accepted in the following cycle.
